// File: rtl/fp_dmem_streamer_if.sv
// Stream handshake bundle for fp_dmem_streamer.
// The master presents a word with m_valid; the slave accepts it with m_ready.
interface fp_dmem_streamer_if #(
    parameter int DW = 16
);
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/fp_dmem_streamer.sv
// FP operand RAM with a base/length/stride address-walk streamer.
// Output path: one synchronous RAM read stage feeding a 2-entry fall-through FIFO.
module fp_dmem_streamer #(
    parameter int DW = 16,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [AW:0]   len,
    input  logic [AW-1:0] stride,
    output logic          busy,
    output logic          done,
    fp_dmem_streamer_if.master m
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] stride_q, stride_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   issued_q, issued_d;

    logic          rd_vld_q, rd_vld_d;
    logic          rd_last_q, rd_last_d;
    logic [DW-1:0] rd_data_q;

    logic [DW-1:0] fifo_data_q [2];
    logic [1:0]    fifo_last_q;
    logic          fifo_wptr_q, fifo_wptr_d;
    logic          fifo_rptr_q, fifo_rptr_d;
    logic [1:0]    fifo_cnt_q, fifo_cnt_d;

    logic [DW-1:0] mem [DEPTH];

    logic          fifo_empty;
    logic          hs;
    logic          push;
    logic          pop;
    logic          issue;
    logic          head_last;
    logic [DW-1:0] head_data;
    logic [2:0]    occ;

    // The read stage output is exposed directly when the FIFO is empty,
    // which gives first-word fall-through without an extra cycle.
    assign fifo_empty = (fifo_cnt_q == 2'd0);
    assign m.m_valid  = !fifo_empty || rd_vld_q;
    assign head_data  = fifo_empty ? rd_data_q : fifo_data_q[fifo_rptr_q];
    assign head_last  = fifo_empty ? rd_last_q : fifo_last_q[fifo_rptr_q];
    assign m.m_data   = m.m_valid ? head_data : '0;
    assign m.m_last   = m.m_valid & head_last;

    assign hs   = m.m_valid & m.m_ready;
    assign push = rd_vld_q & ~(fifo_empty & m.m_ready);
    assign pop  = ~fifo_empty & hs;

    // Words held after this cycle plus a new read must fit in two slots.
    assign occ = {2'b00, rd_vld_q} + {1'b0, fifo_cnt_q}
               - {2'b00, hs};

    assign issue = (state_q == S_RUN)
                && (issued_q < len_q)
                && (occ < 3'd2);

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

    // RAM is deliberately not reset; read-first falls out of the NBA ordering.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (issue) begin
            rd_data_q <= mem[addr_q];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (hs && head_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d    = addr_q;
        stride_d  = stride_q;
        len_d     = len_q;
        issued_d  = issued_q;
        rd_vld_d  = issue;
        rd_last_d = issue && (issued_q == len_q - (AW+1)'(1));
        if (state_q == S_IDLE && start) begin
            addr_d   = base;
            stride_d = stride;
            len_d    = len;
            issued_d = '0;
        end else if (issue) begin
            addr_d   = addr_q + stride_q;
            issued_d = issued_q + (AW+1)'(1);
        end
    end

    always_comb begin
        fifo_wptr_d = fifo_wptr_q;
        fifo_rptr_d = fifo_rptr_q;
        fifo_cnt_d  = fifo_cnt_q;
        if (push) begin
            fifo_wptr_d = ~fifo_wptr_q;
        end
        if (pop) begin
            fifo_rptr_d = ~fifo_rptr_q;
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            stride_q    <= '0;
            len_q       <= '0;
            issued_q    <= '0;
            rd_vld_q    <= 1'b0;
            rd_last_q   <= 1'b0;
            fifo_wptr_q <= 1'b0;
            fifo_rptr_q <= 1'b0;
            fifo_cnt_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            len_q       <= len_d;
            issued_q    <= issued_d;
            rd_vld_q    <= rd_vld_d;
            rd_last_q   <= rd_last_d;
            fifo_wptr_q <= fifo_wptr_d;
            fifo_rptr_q <= fifo_rptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q    <= 2'b00;
        end else if (push) begin
            fifo_data_q[fifo_wptr_q] <= rd_data_q;
            fifo_last_q[fifo_wptr_q] <= rd_last_q;
        end
    end
endmodule

// File: tb/tb_fp_dmem_streamer.sv
// Scoreboard bench for fp_dmem_streamer.
// Expected beats come from a bench-side RAM copy and the base+k*stride formula.
module tb_fp_dmem_streamer;
    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic [8:0]  base;
    logic [9:0]  len;
    logic [8:0]  stride;
    logic        busy;
    logic        done;

    int tests;
    int fails;

    logic [15:0] model [512];
    logic [16:0] sb [$];

    fp_dmem_streamer_if #(.DW(16)) sif ();

    fp_dmem_streamer #(.DW(16), .AW(9)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .base    (base),
        .len     (len),
        .stride  (stride),
        .busy    (busy),
        .done    (done),
        .m       (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wr(input int a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = 9'(a);
        wr_data = d;
        model[a] = d;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic preload_case1();
        wr(0, 16'h4601);
        wr(1, 16'h38B4);
        wr(2, 16'h3C9D);
        wr(3, 16'h3B9C);
    endtask

    // Launch a walk, then observe each cycle at the negedge (c = cycles since T).
    task automatic run_walk(
        input  logic [8:0] b,
        input  logic [9:0] l,
        input  logic [8:0] s,
        input  int         bp,
        input  bit         pulse_mid,
        output int         beats,
        output int         done_c,
        output int         first_v,
        output int         busy_n,
        output int         last_c
    );
        int pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        bit held;
        logic [15:0] hd;
        logic hl;
        logic [16:0] exp;
        beats = 0; done_c = -1; first_v = -1; busy_n = 0; last_c = -1;
        held = 1'b0; hd = '0; hl = 1'b0;
        for (int k = 0; k < int'(l); k++) begin
            sb.push_back({(k == int'(l) - 1), model[(int'(b) + k * int'(s)) % 512]});
        end
        start = 1'b1; base = b; len = l; stride = s;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 800; c++) begin
            if (busy) busy_n++;
            if (done) begin
                done_c = c;
                break;
            end
            start = (pulse_mid && c == 3);
            if (sif.m_valid) begin
                if (first_v < 0) first_v = c;
                if (held) begin
                    tests++;
                    if (sif.m_data !== hd || sif.m_last !== hl) begin
                        fails++;
                        $display("FAIL hold c=%0d: got %h/%b required %h/%b", c, sif.m_data, sif.m_last, hd, hl);
                    end
                end
                sif.m_ready = (bp != 0 && c >= 2 && c - 2 < 7) ? pat[c-2][0] : 1'b1;
                if (sif.m_ready) begin
                    held = 1'b0;
                    beats++;
                    if (sif.m_last) last_c = c;
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL extra_beat: got %h required none", sif.m_data);
                    end else begin
                        exp = sb.pop_front();
                        if ({sif.m_last, sif.m_data} !== exp) begin
                            fails++;
                            $display("FAIL beat%0d: got %b/%h required %b/%h", beats, sif.m_last, sif.m_data, exp[16], exp[15:0]);
                        end
                    end
                end else begin
                    held = 1'b1;
                    hd = sif.m_data;
                    hl = sif.m_last;
                end
            end else begin
                tests++;
                if (held) begin
                    fails++;
                    $display("FAIL valid_drop c=%0d: got 0 required 1", c);
                end
                sif.m_ready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        start = 1'b0;
        sif.m_ready = 1'b1;
        tests++;
        if (done_c < 0) begin
            fails++;
            $display("FAIL timeout: got no done required done");
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL missing_beats: got %0d left required 0", sb.size());
        end
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            tests++;
            if (sif.m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL post_idle: got v%b b%b d%b required 000", sif.m_valid, busy, done);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        tests++;
        if ({busy, done, sif.m_valid, sif.m_last, sif.m_data} !== 20'h0) begin
            fails++;
            $display("FAIL reset: got %b%b%b%b %h required 0", busy, done, sif.m_valid, sif.m_last, sif.m_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int bt, dc, fv, bn, lc;
        preload_case1();
        run_walk(9'd0, 10'd4, 9'd1, 0, 1'b0, bt, dc, fv, bn, lc);
        tests++;
        if (bt !== 4 || fv !== 2 || lc !== 5) begin
            fails++;
            $display("FAIL basic_timing: got beats%0d fv%0d last%0d required 4/2/5", bt, fv, lc);
        end
        tests++;
        if (dc !== 6 || bn !== 5) begin
            fails++;
            $display("FAIL basic_done: got done%0d busy%0d required 6/5", dc, bn);
        end
    endtask

    task automatic test_wrap();
        int bt, dc, fv, bn, lc;
        wr(510, 16'h30D2);
        wr(511, 16'hB8B4);
        run_walk(9'd510, 10'd4, 9'd1, 0, 1'b0, bt, dc, fv, bn, lc);
        tests++;
        if (bt !== 4 || dc !== 6) begin
            fails++;
            $display("FAIL wrap: got beats%0d done%0d required 4/6", bt, dc);
        end
    endtask

    task automatic test_stride();
        int bt, dc, fv, bn, lc;
        wr(20, 16'h8000);
        wr(40, 16'h0000);
        run_walk(9'd0, 10'd3, 9'd20, 0, 1'b0, bt, dc, fv, bn, lc);
        tests++;
        if (bt !== 3 || lc !== 4) begin
            fails++;
            $display("FAIL stride: got beats%0d last%0d required 3/4", bt, lc);
        end
    endtask

    task automatic test_backpressure();
        int bt, dc, fv, bn, lc;
        run_walk(9'd0, 10'd4, 9'd1, 1, 1'b0, bt, dc, fv, bn, lc);
        tests++;
        if (bt !== 4 || lc !== 8 || dc !== 9) begin
            fails++;
            $display("FAIL backpressure: got beats%0d last%0d done%0d required 4/8/9", bt, lc, dc);
        end
    endtask

    task automatic test_len0();
        int bt, dc, fv, bn, lc;
        run_walk(9'd5, 10'd0, 9'd1, 0, 1'b0, bt, dc, fv, bn, lc);
        tests++;
        if (dc !== 1 || bn !== 0 || fv !== -1) begin
            fails++;
            $display("FAIL len0: got done%0d busy%0d fv%0d required 1/0/-1", dc, bn, fv);
        end
    endtask

    task automatic test_start_ignored();
        int bt, dc, fv, bn, lc;
        run_walk(9'd0, 10'd4, 9'd1, 0, 1'b1, bt, dc, fv, bn, lc);
        tests++;
        if (bt !== 4 || dc !== 6) begin
            fails++;
            $display("FAIL start_ignored: got beats%0d done%0d required 4/6", bt, dc);
        end
    endtask

    task automatic test_reset_midwalk();
        int beats;
        logic [16:0] exp;
        for (int a = 4; a < 8; a++) wr(a, 16'(16'h1000 + a));
        for (int k = 0; k < 8; k++) sb.push_back({(k == 7), model[k]});
        beats = 0;
        start = 1'b1; base = 9'd0; len = 10'd8; stride = 9'd1;
        sif.m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20 && beats < 2; c++) begin
            if (sif.m_valid) begin
                beats++;
                exp = sb.pop_front();
                tests++;
                if ({sif.m_last, sif.m_data} !== exp) begin
                    fails++;
                    $display("FAIL midwalk_beat%0d: got %h required %h", beats, sif.m_data, exp[15:0]);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        sb.delete();
        rst_n = 1'b0;
        #1;
        tests++;
        if (sif.m_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL midwalk_reset: got v%b b%b required 00", sif.m_valid, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ram_retained();
        int bt, dc, fv, bn, lc;
        run_walk(9'd0, 10'd4, 9'd1, 0, 1'b0, bt, dc, fv, bn, lc);
        tests++;
        if (bt !== 4 || fv !== 2 || dc !== 6) begin
            fails++;
            $display("FAIL retained: got beats%0d fv%0d done%0d required 4/2/6", bt, fv, dc);
        end
    endtask

    task automatic test_full_and_zero_stride();
        int bt, dc, fv, bn, lc;
        for (int a = 0; a < 512; a++) wr(a, 16'($urandom));
        run_walk(9'd37, 10'd512, 9'd1, 0, 1'b0, bt, dc, fv, bn, lc);
        tests++;
        if (bt !== 512 || dc !== 514) begin
            fails++;
            $display("FAIL full: got beats%0d done%0d required 512/514", bt, dc);
        end
        run_walk(9'd20, 10'd5, 9'd0, 0, 1'b0, bt, dc, fv, bn, lc);
        tests++;
        if (bt !== 5) begin
            fails++;
            $display("FAIL zero_stride: got beats%0d required 5", bt);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; base = '0; len = '0; stride = '0;
        sif.m_ready = 1'b1;
        test_reset();
        test_basic();
        test_wrap();
        test_stride();
        test_backpressure();
        test_len0();
        test_start_ignored();
        test_reset_midwalk();
        test_ram_retained();
        test_full_and_zero_stride();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
